// File: rtl/sram_arbiter.sv
// sram_arbiter
// Arbitrates a single-port asynchronous SRAM between an instruction-fetch
// port (read only) and a data port (read/write). Data requests win whenever
// both are pending in IDLE. Each transfer holds the SRAM for WAIT_CYCLES
// clocks, then pulses the granted requester's ready for one cycle.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_req/if_addr           fetch request and byte address
//   if_rdata/if_ready        fetched word and one-cycle completion pulse
//   mem_r_en/mem_w_en        data read/write requests (both set = write)
//   mem_addr/mem_wdata       data byte address and write data
//   mem_rdata/mem_ready      read data and one-cycle completion pulse
//   if_freeze/mem_freeze     combinational stalls for each requester
//   sram_addr/sram_wdata     SRAM word address and write data
//   sram_rdata               SRAM read data
//   sram_ce_n/sram_we_n      active-low chip enable / write enable
//
// state  | meaning
// IDLE   | no transfer; grants the next request (data first)
// ACCESS | SRAM enabled, wait counter running down to 0
// DONE   | one-cycle ready pulse to the granted requester

module sram_arbiter #(
    parameter int WAIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        if_freeze,
    output logic        mem_freeze,
    output logic [15:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    output logic        sram_ce_n,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic        grant;
    logic        mem_req;
    logic [3:0]  cnt_q;
    logic        sel_mem_q;
    logic        wr_q;
    logic [15:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    // Only word-address bits [17:2] reach the SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:18], if_addr[1:0],
                                mem_addr[31:18], mem_addr[1:0]};

    assign mem_req = mem_r_en | mem_w_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req || if_req) begin
                    grant   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= 4'd0;
            sel_mem_q <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= 16'd0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
        end else if (grant) begin
            // Data port wins in IDLE; fetches are always reads.
            sel_mem_q <= mem_req;
            wr_q      <= mem_req & mem_w_en;
            addr_q    <= mem_req ? mem_addr[17:2] : if_addr[17:2];
            wdata_q   <= mem_wdata;
            cnt_q     <= CNT_LOAD;
        end else if (state_q == ACCESS) begin
            if (cnt_q == 4'd0) begin
                if (!wr_q) begin
                    rdata_q <= sram_rdata;
                end
            end else begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    assign sram_ce_n  = (state_q != ACCESS);
    assign sram_we_n  = !((state_q == ACCESS) && wr_q);
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

    assign if_ready   = (state_q == DONE) && !sel_mem_q;
    assign mem_ready  = (state_q == DONE) && sel_mem_q;
    assign if_rdata   = rdata_q;
    assign mem_rdata  = rdata_q;

    assign if_freeze  = if_req & ~if_ready;
    assign mem_freeze = mem_req & ~mem_ready;

endmodule
